// File: rtl/stopwatch_timer.sv
// Stopwatch SS.cc (00.00..59.99) on four active-low 7-segment digits, KEY1 start/pause, KEY0 sync reset.
// Latency: KEY1 press toggles run on the 3rd edge; display is combinational from registered counters.
module stopwatch_timer #(
    parameter int TICK_DIV = 500_000
) (
    input  logic       clk,
    input  logic       KEY0,
    input  logic       KEY1,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic       LEDR0
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    // Button synchronizer and edge detector idle high (button released)
    logic          k1_q = 1'b1;
    logic          k2_q = 1'b1;
    logic          kp_q = 1'b1;
    logic [PW-1:0] presc_q = '0;
    logic [6:0]    cs_q = '0;
    logic [5:0]    sec_q = '0;
    logic          run_q = 1'b0;

    logic [PW-1:0] presc_d;
    logic [6:0]    cs_d;
    logic [5:0]    sec_d;
    logic          run_d;
    logic          press;
    logic          tick;

    assign press = kp_q & ~k2_q;
    assign tick  = run_q && (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q;
        cs_d    = cs_q;
        sec_d   = sec_q;
        // A tick on the press edge still counts with the old run value
        run_d   = run_q ^ press;
        if (run_q) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            if (cs_q == 7'd99) begin
                cs_d  = '0;
                sec_d = (sec_q == 6'd59) ? '0 : sec_q + 1'b1;
            end else begin
                cs_d = cs_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!KEY0) begin
            k1_q    <= 1'b1;
            k2_q    <= 1'b1;
            kp_q    <= 1'b1;
            presc_q <= '0;
            cs_q    <= '0;
            sec_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            k1_q    <= KEY1;
            k2_q    <= k1_q;
            kp_q    <= k2_q;
            presc_q <= presc_d;
            cs_q    <= cs_d;
            sec_q   <= sec_d;
            run_q   <= run_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [3:0] cs_ones, cs_tens, sec_ones, sec_tens;

    assign cs_ones  = 4'(cs_q % 7'd10);
    assign cs_tens  = 4'(cs_q / 7'd10);
    assign sec_ones = 4'(sec_q % 6'd10);
    assign sec_tens = 4'(sec_q / 6'd10);

    assign HEX0  = seg7(cs_ones);
    assign HEX1  = seg7(cs_tens);
    assign HEX2  = seg7(sec_ones);
    assign HEX3  = seg7(sec_tens);
    assign LEDR0 = run_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Bench for stopwatch_timer with TICK_DIV=4: directed vector table, wrap sequence, random stimulus vs model.
module tb_stopwatch_timer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       KEY0 = 1'b1;
    logic       KEY1 = 1'b1;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;
    logic       LEDR0;

    int checks = 0;
    int failures = 0;

    stopwatch_timer #(.TICK_DIV(TD)) dut (
        .clk  (clk),
        .KEY0 (KEY0),
        .KEY1 (KEY1),
        .HEX0 (HEX0),
        .HEX1 (HEX1),
        .HEX2 (HEX2),
        .HEX3 (HEX3),
        .LEDR0(LEDR0)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10];

    // Reference model: elapsed running cycles and the raw history of KEY1 samples
    int   m_cycles = 0;
    bit   m_run = 1'b0;
    bit   h1 = 1'b1, h2 = 1'b1, h3 = 1'b1;

    function automatic logic [27:0] disp_of(input int total_cs);
        int t;
        t = total_cs % 6000;
        disp_of = {seg_tab[(t / 100) / 10], seg_tab[(t / 100) % 10],
                   seg_tab[(t % 100) / 10], seg_tab[t % 10]};
    endfunction

    task automatic model_edge(input bit k0, input bit k1);
        bit press;
        if (!k0) begin
            m_cycles = 0;
            m_run    = 1'b0;
            h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
        end else begin
            press = (h3 == 1'b1) && (h2 == 1'b0);
            if (m_run) m_cycles++;
            m_run = m_run ^ press;
            h3 = h2; h2 = h1; h1 = k1;
        end
    endtask

    task automatic chk(input string name, input int total_cs, input bit led);
        logic [27:0] act, exp;
        act = {HEX3, HEX2, HEX1, HEX0};
        exp = disp_of(total_cs);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: hex=%h required %h (time %0d cs)", name, act, exp, total_cs % 6000);
        end
        checks++;
        if (LEDR0 !== led) begin
            failures++;
            $display("FAIL %s: LEDR0=%b required %b", name, LEDR0, led);
        end
    endtask

    task automatic step(input bit k0, input bit k1);
        @(negedge clk);
        KEY0 = k0;
        KEY1 = k1;
        @(posedge clk);
        model_edge(k0, k1);
        #1;
    endtask

    typedef struct {
        bit    k0;
        bit    k1;
        int    reps;
        bit    exp_led;
        int    exp_cs;
        string name;
    } vec_t;

    vec_t vecs [$];

    initial begin
        bit rk1;
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;

        vecs = '{
            '{0, 1,   1, 0,   0, "reset"},
            '{1, 0,   1, 0,   0, "start_e1"},
            '{1, 1,   1, 0,   0, "start_e2"},
            '{1, 1,   1, 1,   0, "start_e3_run"},
            '{1, 1,   3, 1,   0, "pre_first_tick"},
            '{1, 1,   1, 1,   1, "first_tick"},
            '{1, 1, 396, 1, 100, "one_second"},
            '{1, 0,   1, 1, 100, "pause_e1"},
            '{1, 1,   1, 1, 100, "pause_e2"},
            '{1, 1,   1, 0, 100, "pause_e3"},
            '{1, 1, 100, 0, 100, "frozen"},
            '{1, 0,   1, 0, 100, "resume_e1"},
            '{1, 1,   1, 0, 100, "resume_e2"},
            '{1, 1,   1, 1, 100, "resume_e3"},
            '{1, 1,   1, 1, 101, "phase_kept"},
            '{1, 0,  50, 0, 101, "hold_one_toggle"},
            '{1, 1,   5, 0, 101, "release_noop"},
            '{1, 0,   1, 0, 101, "run2_e1"},
            '{1, 1,   1, 0, 101, "run2_e2"},
            '{1, 1,   1, 1, 101, "run2_e3"},
            '{1, 1,   2, 1, 102, "run2_tick"},
            '{1, 0,   1, 1, 102, "rst_press_e1"},
            '{1, 1,   1, 1, 102, "rst_press_e2"},
            '{0, 0,   1, 0,   0, "reset_beats_press"},
            '{1, 1,   5, 0,   0, "after_reset_idle"}
        };

        #1;
        chk("power_on", 0, 1'b0);

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) step(vecs[i].k0, vecs[i].k1);
            chk(vecs[i].name, vecs[i].exp_cs, vecs[i].exp_led);
        end

        // Full-range wrap: 59.99 -> 00.00 while running
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int c = 0; c < 5999 * TD; c++) step(1'b1, 1'b1);
        chk("at_59_99", 5999, 1'b1);
        for (int c = 0; c < TD; c++) step(1'b1, 1'b1);
        chk("wrap_00_00", 0, 1'b1);

        // Randomized stimulus against the model
        step(1'b0, 1'b1);
        rk1 = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) rk1 = ~rk1;
            step($urandom_range(0, 199) != 0, rk1);
            chk("random", m_cycles / TD, m_run);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
